// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers for a simple in-order core: the fetch PC,
// the IF/ID latch, the ID/EX latch with operand forwarding selection, two
// saturating performance counters, and a sticky hazard-consistency flag.
// Every output is a flop, so nothing here is combinational from input to output.

package pipe_front_pkg;

    // Operand source encoding for the ID/EX A and B operand muxes.
    typedef enum logic [1:0] {
        SRC_REG = 2'b00,  // register-file read port (pa / pb)
        SRC_EX  = 2'b01,  // forwarded from the EX stage result
        SRC_MEM = 2'b10,  // forwarded from the MEM stage result
        SRC_WB  = 2'b11   // forwarded from the WB stage result
    } src_sel_e;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'd0;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage : pipe_front_pkg

module pipe_front_regs
    import pipe_front_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    // Hazard unit controls
    input  logic        pc_enable,
    input  logic        ifid_enable,
    input  logic        nop_insertion_s,   // active-low: 0 injects a bubble into ID/EX
    input  logic [1:0]  mux_s_a,
    input  logic [1:0]  mux_s_b,

    // Branch redirect
    input  logic        branch_taken,
    input  logic [31:0] branch_target,

    // Fetch
    input  logic [31:0] instr_in,

    // Operand sources
    input  logic [31:0] pa,
    input  logic [31:0] pb,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,

    // Decode results
    input  logic [7:0]  id_ctrl,
    input  logic [3:0]  id_rd,

    // Fetch state and IF/ID
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,

    // ID/EX
    output logic [31:0] idex_a,
    output logic [31:0] idex_b,
    output logic [7:0]  idex_ctrl,
    output logic [3:0]  idex_rd,

    // Performance and diagnostics
    output logic [15:0] stall_count,
    output logic [15:0] fwd_count,
    output logic        hazard_mismatch
);

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [31:0] pc_next;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        bubble;
    logic        forwarding;
    logic        controls_disagree;

    // The hazard unit drives nop_insertion_s low to request a bubble.
    assign bubble = ~nop_insertion_s;

    // A forwarding event is any live instruction that takes at least one
    // operand from a later stage; two forwarded operands still count once.
    assign forwarding = nop_insertion_s &&
                        ((src_sel_e'(mux_s_a) != SRC_REG) ||
                         (src_sel_e'(mux_s_b) != SRC_REG));

    // The three stall controls are meant to move together; any split is a
    // hazard-unit bug worth latching for later inspection.
    assign controls_disagree = (pc_enable != ifid_enable) ||
                               (pc_enable != nop_insertion_s);

    // Operand source select, shared by the A and B muxes.
    function automatic logic [31:0] pick_operand(
        input logic [1:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] ex_val,
        input logic [31:0] mem_val,
        input logic [31:0] wb_val
    );
        logic [31:0] result;
        unique case (src_sel_e'(sel))
            SRC_REG: result = reg_val;
            SRC_EX:  result = ex_val;
            SRC_MEM: result = mem_val;
            SRC_WB:  result = wb_val;
            default: result = reg_val;
        endcase
        return result;
    endfunction

    // Next PC and forwarded operand values; redirect beats advance beats hold.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        pc_next   = pc;
        operand_a = pick_operand(mux_s_a, pa, ex_result, mem_result, wb_result);
        operand_b = pick_operand(mux_s_b, pb, ex_result, mem_result, wb_result);

        if (branch_taken) begin
            pc_next = branch_target;
        end else if (pc_enable) begin
            pc_next = pc + PC_STEP;  // wraps naturally at 2^32
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: reset is asynchronous, so it appears in the sensitivity list
        // and clears state without waiting for a clock edge.
        if (!rst_n) begin
            pc <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples the pre-edge values of its sources.
            pc <= pc_next;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID latch
    // ------------------------------------------------------------------

    // IF/ID: flush to a NOP on redirect, otherwise load when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr <= NOP_WORD;
            ifid_pc    <= '0;
        end else if (branch_taken) begin
            ifid_instr <= NOP_WORD;
            ifid_pc    <= '0;
        end else if (ifid_enable) begin
            ifid_instr <= instr_in;
            ifid_pc    <= pc;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX latch
    // ------------------------------------------------------------------

    // ID/EX loads every cycle: either a bubble or the decoded instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_a    <= '0;
            idex_b    <= '0;
            idex_ctrl <= '0;
            idex_rd   <= '0;
        end else if (bubble) begin
            idex_a    <= '0;
            idex_b    <= '0;
            idex_ctrl <= '0;
            idex_rd   <= '0;
        end else begin
            idex_a    <= operand_a;
            idex_b    <= operand_b;
            idex_ctrl <= id_ctrl;
            idex_rd   <= id_rd;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

    // Bubble counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (bubble && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Forwarding counter, one per forwarding cycle, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count <= '0;
        end else if (forwarding && (fwd_count != CNT_MAX)) begin
            fwd_count <= fwd_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Diagnostics
    // ------------------------------------------------------------------

    // Sticky flag: once the stall controls disagree, stay set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_mismatch <= 1'b0;
        end else if (controls_disagree) begin
            hazard_mismatch <= 1'b1;
        end
    end

endmodule : pipe_front_regs

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL have port pc_enable  input  1  1 = PC may advance; 0 = hold PC (load-hazard stall).
REQ-004 SHALL have port ifid_enable  input  1  1 = IF/ID may load; 0 = hold IF/ID.
REQ-005 SHALL have port nop_insertion_s  input  1  active-low: 0 = inject NOP into ID/EX; 1 = pass decoded instruction.
REQ-006 SHALL have ports mux_s_a, mux_s_b  input  2 each  operand source select: 00 = PA/PB, 01 = EX result, 10 = MEM result, 11 = WB result.
REQ-007 SHALL have ports branch_taken  input  1 and branch_target  input  32  redirect request and target address.
REQ-008 SHALL have port instr_in  input  32  instruction fetched at current PC.
REQ-009 SHALL have ports pa, pb, ex_result, mem_result, wb_result  input  32 each  register-file outputs and forwarded values.
REQ-010 SHALL have ports id_ctrl  input  8 and id_rd  input  4  decoded control word and destination register.
REQ-011 SHALL have outputs pc  32, ifid_instr  32, ifid_pc  32  fetch PC and IF/ID contents.
REQ-012 SHALL have outputs idex_a  32, idex_b  32, idex_ctrl  8, idex_rd  4  ID/EX contents.
REQ-013 SHALL have outputs stall_count  16 and fwd_count  16  saturating performance counters.
REQ-014 SHALL have output hazard_mismatch  1  sticky error flag.

Function
REQ-015 SHALL update PC with priority: branch_taken -> branch_target; else pc_enable=1 -> pc+4, mod 2^32 (0xFFFFFFFC wraps to 0); else hold.
REQ-016 SHALL update IF/ID with priority: branch_taken -> ifid_instr=0 (NOP), ifid_pc=0; else ifid_enable=1 -> ifid_instr=instr_in, ifid_pc=pc; else hold.
REQ-017 SHALL load ID/EX every cycle, with no enable.
REQ-018 When nop_insertion_s=0, SHALL load idex_ctrl=0, idex_rd=0, idex_a=0, idex_b=0.
REQ-019 When nop_insertion_s=1, SHALL load idex_ctrl=id_ctrl, idex_rd=id_rd, and idex_a/idex_b selected by mux_s_a/mux_s_b per REQ-006; the selection is independent for A and B.
REQ-020 When branch_taken=1 and nop_insertion_s=0 occur together, SHALL apply both: redirect plus flush per REQ-015/016, and NOP into ID/EX per REQ-018.
REQ-021 SHALL increment stall_count on each cycle with nop_insertion_s=0, saturating at 0xFFFF.
REQ-022 SHALL increment fwd_count by 1 on each cycle with nop_insertion_s=1 and (mux_s_a!=00 or mux_s_b!=00), saturating at 0xFFFF; a cycle where both operands are forwarded still counts 1.
REQ-023 SHALL set hazard_mismatch on a clock edge where pc_enable, ifid_enable and nop_insertion_s are not all equal; once set, SHALL stay 1 until reset.
REQ-024 SHALL have a latency of one cycle from inputs to all registered outputs; SHALL have no combinational input-to-output paths.

Reset
REQ-025 On rst_n=0, SHALL immediately (asynchronously) clear pc, ifid_instr, ifid_pc, idex_a, idex_b, idex_ctrl, idex_rd, stall_count, fwd_count and hazard_mismatch to 0.
REQ-026 On an rst_n assertion mid-stall or mid-branch, SHALL discard the pending update; the first edge after release SHALL follow REQ-015..023 from the all-zero state.

Verification
REQ-027 Release reset; hold pc_enable=ifid_enable=nop_insertion_s=1 for 3 cycles with instr_in=0xE0811002 -> pc=0x0C, ifid_pc=0x08, ifid_instr=0xE0811002.
REQ-028 Drive a stall (all three hazard controls 0) for 2 cycles from pc=0x10 -> pc and IF/ID hold, idex_ctrl=0, stall_count +2, hazard_mismatch=0.
REQ-029 Drive nop_insertion_s=1, mux_s_a=01, mux_s_b=11, ex_result=0xAAAA0000, wb_result=0x5555 -> idex_a=0xAAAA0000, idex_b=0x00005555, fwd_count +1.
REQ-030 Drive branch_taken=1, branch_target=0x100, together with pc_enable=0 -> pc=0x100, ifid_instr=0, ifid_pc=0.
REQ-031 Drive pc_enable=0 with ifid_enable=1 for 1 cycle, then return all three to 1 -> hazard_mismatch=1 and stays 1; then assert rst_n=0 -> all outputs 0 without waiting for a clock edge.
REQ-032 Preload stall_count to 0xFFFE via 0xFFFE stall cycles, then stall 3 more cycles -> stall_count=0xFFFF; start from pc=0xFFFFFFFC with pc_enable=1 -> pc=0x00000000.
